apb_rr_master: RTL and testbench

- Two-requester APB master with round-robin arbitration.
- Accepts single-word read/write commands from two independent requester ports and serialises them onto one APB bus.
- Decodes the address into one of P_NUM PSEL lines and returns read data and error status to the requester that issued the command.
- Sits between bench/CPU-side command sources and the APB slave memories (P_NUM slaves).

---
 rtl/apb_rr_master_if.sv | 48 ++++
 rtl/apb_rr_master.sv | 187 ++++++++++++++++++
 tb/tb_apb_rr_master.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_master_if.sv
// +------------------------------------------------------------------+
// | Module  : apb_rr_master_if                                       |
// | Desc    : Requester command ports and APB bus of apb_rr_master   |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface apb_rr_master_if #(
  parameter int P_NUM    = 4,
  parameter int P_DWIDTH = 32
);
  logic [1:0]          REQ_VALID;
  logic [1:0]          REQ_WRITE;
  logic [31:0]         REQ_ADDR0;
  logic [31:0]         REQ_ADDR1;
  logic [P_DWIDTH-1:0] REQ_WDATA0;
  logic [P_DWIDTH-1:0] REQ_WDATA1;
  logic [1:0]          REQ_DONE;
  logic [P_DWIDTH-1:0] REQ_RDATA;
  logic                REQ_ERR;
  logic [P_NUM-1:0]    PSEL;
  logic [31:0]         PADDR;
  logic                PENABLE;
  logic                PWRITE;
  logic [P_DWIDTH-1:0] PWDATA;
  logic [P_DWIDTH-1:0] PRDATA0;
  logic [P_DWIDTH-1:0] PRDATA1;
  logic [P_DWIDTH-1:0] PRDATA2;
  logic [P_DWIDTH-1:0] PRDATA3;
  logic [P_NUM-1:0]    PREADY;
  logic [P_NUM-1:0]    PSLVERR;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR0, REQ_ADDR1, REQ_WDATA0, REQ_WDATA1,
    output REQ_DONE, REQ_RDATA, REQ_ERR,
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY, PSLVERR
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR0, REQ_ADDR1, REQ_WDATA0, REQ_WDATA1,
    input  REQ_DONE, REQ_RDATA, REQ_ERR,
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/apb_rr_master.sv
// +------------------------------------------------------------------+
// | Module  : apb_rr_master                                          |
// | Desc    : Two-requester round-robin APB master, P_NUM slaves.    |
// |           Optional ACCESS timeout: APB_RR_MASTER_TIMEOUT_EN      |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module apb_rr_master #(
  parameter int          P_NUM         = 4,
  parameter int          P_DWIDTH      = 32,
  parameter logic [31:0] P_ADDR_START0 = 32'h0000_0000,
  parameter logic [31:0] P_ADDR_START1 = 32'h0001_0000,
  parameter logic [31:0] P_ADDR_START2 = 32'h0002_0000,
  parameter logic [31:0] P_ADDR_START3 = 32'h0003_0000,
  parameter int          P_SIZE        = 1024,
  parameter int          P_TIMEOUT     = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_rr_master_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [31:0] c_START [4] = '{P_ADDR_START0, P_ADDR_START1,
                                          P_ADDR_START2, P_ADDR_START3};

  state_t              state_q;
  logic                rr_q;      // requester favoured on the next contested grant
  logic                gnt_q;
  logic [1:0]          sel_q;
  logic [P_NUM-1:0]    psel_q;
  logic [31:0]         paddr_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [P_DWIDTH-1:0] pwdata_q;
  logic [1:0]          done_q;
  logic [P_DWIDTH-1:0] rdata_q;
  logic                err_q;

  logic                w_gnt;
  logic [31:0]         w_addr;
  logic                w_wr;
  logic [P_DWIDTH-1:0] w_wdata;
  logic [P_NUM-1:0]    w_hit;
  logic [P_NUM-1:0]    w_sel_oh;
  logic [1:0]          w_sel_idx;
  logic                w_miss;
  logic [3:0]          w_ready_v;
  logic [3:0]          w_slverr_v;
  logic                w_ready;
  logic                w_slverr;
  logic [P_DWIDTH-1:0] w_prdata;

  assign w_gnt   = (&bus.REQ_VALID) ? rr_q : bus.REQ_VALID[1];
  assign w_addr  = w_gnt ? bus.REQ_ADDR1 : bus.REQ_ADDR0;
  assign w_wr    = bus.REQ_WRITE[w_gnt];
  assign w_wdata = w_gnt ? bus.REQ_WDATA1 : bus.REQ_WDATA0;

  for (genvar gi = 0; gi < P_NUM; gi++) begin : g_dec
    assign w_hit[gi] = (w_addr >= c_START[gi]) &&
                       ((w_addr - c_START[gi]) < 32'(P_SIZE));
  end

  // Lowest-numbered window wins should windows ever overlap.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = 2'd0;
    w_miss    = 1'b1;
    for (int i = P_NUM - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_idx   = 2'(i);
        w_miss      = 1'b0;
      end
    end
  end

  assign w_ready_v  = 4'(bus.PREADY);
  assign w_slverr_v = 4'(bus.PSLVERR);
  assign w_ready    = w_ready_v[sel_q];
  assign w_slverr   = w_slverr_v[sel_q];

  always_comb begin
    case (sel_q)
      2'd0:    w_prdata = bus.PRDATA0;
      2'd1:    w_prdata = bus.PRDATA1;
      2'd2:    w_prdata = bus.PRDATA2;
      default: w_prdata = bus.PRDATA3;
    endcase
  end

`ifdef APB_RR_MASTER_TIMEOUT_EN
  localparam int c_TW = $clog2(P_TIMEOUT + 1);
  logic [c_TW-1:0] wcnt_q;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      sel_q     <= 2'd0;
      psel_q    <= '0;
      paddr_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_RR_MASTER_TIMEOUT_EN
      wcnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|bus.REQ_VALID) begin
            gnt_q <= w_gnt;
            rr_q  <= ~w_gnt;
            if (!w_miss) begin
              psel_q   <= w_sel_oh;
              sel_q    <= w_sel_idx;
              paddr_q  <= w_addr;
              pwrite_q <= w_wr;
              if (w_wr) pwdata_q <= w_wdata;
              state_q  <= S_SETUP;
            end else begin
              // Unmapped address: answer straight away without touching the bus.
              err_q   <= 1'b1;
              rdata_q <= '0;
              done_q  <= {w_gnt, ~w_gnt};
              state_q <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
`ifdef APB_RR_MASTER_TIMEOUT_EN
          wcnt_q    <= '0;
`endif
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_ready) begin
            rdata_q   <= pwrite_q ? '0 : w_prdata;
            err_q     <= w_slverr;
            psel_q    <= '0;
            penable_q <= 1'b0;
            done_q    <= {gnt_q, ~gnt_q};
            state_q   <= S_RESP;
          end
`ifdef APB_RR_MASTER_TIMEOUT_EN
          else if (wcnt_q == c_TW'(P_TIMEOUT - 1)) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            done_q    <= {gnt_q, ~gnt_q};
            state_q   <= S_RESP;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
        end
        default: begin
          done_q  <= 2'b00;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.REQ_DONE  = done_q;
  assign bus.REQ_RDATA = rdata_q;
  assign bus.REQ_ERR   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_rr_master.sv
// +------------------------------------------------------------------+
// | Module  : tb_apb_rr_master                                       |
// | Desc    : Self-checking bench for apb_rr_master                  |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_apb_rr_master;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  localparam logic [31:0] c_ST [4] = '{32'h0000_0000, 32'h1000_0000,
                                       32'h0002_0000, 32'h0003_0000};

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;

  logic        v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
  logic [3:0]  rdy = '0, serr = '0;
  logic [31:0] prd [4];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          waitcfg [4];
  logic [3:0]  serrcfg = '0;
  int          wcnt [4];
  logic [31:0] smem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  cmd_t        q0 [$];
  cmd_t        q1 [$];
  res_t        exp_r0 [$];
  res_t        exp_r1 [$];
  int          exp_order [$];

  int          psel_cyc = 0, pen_cyc = 0;
  logic [3:0]  mon_psel = '0;
  logic [31:0] mon_paddr = '0, last_rdata = '0;
  logic        last_err = 1'b0;

  apb_rr_master_if #(.P_NUM(4), .P_DWIDTH(32)) bus ();

  apb_rr_master #(
    .P_NUM(4), .P_DWIDTH(32),
    .P_ADDR_START0(32'h0000_0000), .P_ADDR_START1(32'h1000_0000),
    .P_ADDR_START2(32'h0002_0000), .P_ADDR_START3(32'h0003_0000),
    .P_SIZE(1024), .P_TIMEOUT(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  assign bus.REQ_VALID  = {v1, v0};
  assign bus.REQ_WRITE  = {w1, w0};
  assign bus.REQ_ADDR0  = a0;
  assign bus.REQ_ADDR1  = a1;
  assign bus.REQ_WDATA0 = d0;
  assign bus.REQ_WDATA1 = d1;
  assign bus.PRDATA0    = prd[0];
  assign bus.PRDATA1    = prd[1];
  assign bus.PRDATA2    = prd[2];
  assign bus.PRDATA3    = prd[3];
  assign bus.PREADY     = rdy;
  assign bus.PSLVERR    = serr;

  always #5 PCLK = ~PCLK;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: decode by address window, memory as a plain associative array.
  task automatic add(int p, bit wr, logic [31:0] a, logic [31:0] d, int lat);
    cmd_t c;
    res_t r;
    int   idx;
    c   = '{wr, a, d, lat};
    idx = -1;
    for (int i = 3; i >= 0; i--)
      if (a >= c_ST[i] && (a - c_ST[i]) < 32'd1024) idx = i;
    if (idx < 0) begin
      r = '{32'h0, 1'b1};
    end else begin
      r.err   = serrcfg[idx];
      r.rdata = wr ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
      if (wr && !r.err) ref_mem[a] = d;
    end
    if (p == 0) begin q0.push_back(c); exp_r0.push_back(r); end
    else        begin q1.push_back(c); exp_r1.push_back(r); end
  endtask

  task automatic run(int budget);
    int         n, s0, s1, dc;
    logic [1:0] dn;
    n = 0; s0 = 0; s1 = 0;
    @(posedge PCLK); #1;
    if (q0.size() > 0) begin v0 = 1; w0 = q0[0].wr; a0 = q0[0].addr; d0 = q0[0].wdata; s0 = cyc; end
    if (q1.size() > 0) begin v1 = 1; w1 = q1[0].wr; a1 = q1[0].addr; d1 = q1[0].wdata; s1 = cyc; end
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      @(negedge PCLK);
      dn = bus.REQ_DONE;
      dc = cyc;
      @(posedge PCLK); #1;
      n++;
      if (dn[0] && q0.size() > 0) begin
        if (q0[0].lat >= 0) check("latency_p0", 32'(dc - s0), 32'(q0[0].lat));
        void'(q0.pop_front());
        if (q0.size() > 0) begin w0 = q0[0].wr; a0 = q0[0].addr; d0 = q0[0].wdata; s0 = cyc; end
        else v0 = 0;
      end
      if (dn[1] && q1.size() > 0) begin
        if (q1[0].lat >= 0) check("latency_p1", 32'(dc - s1), 32'(q1[0].lat));
        void'(q1.pop_front());
        if (q1.size() > 0) begin w1 = q1[0].wr; a1 = q1[0].addr; d1 = q1[0].wdata; s1 = cyc; end
        else v1 = 0;
      end
    end
    if (n >= budget) begin
      check("run_timeout", 32'(q0.size() + q1.size()), 32'h0);
      q0.delete(); q1.delete(); v0 = 0; v1 = 0;
    end
  endtask

  initial begin
    int          p;
    int          n;
    logic [3:0]  prev_sel;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_en, prev_wr, prev_ok;
    logic [1:0]  prev_done;
    res_t        r;

    for (int i = 0; i < 4; i++) begin waitcfg[i] = 0; wcnt[i] = 0; prd[i] = '0; end
    prev_ok = 0; prev_sel = '0; prev_addr = '0; prev_wdata = '0;
    prev_en = 0; prev_wr = 0; prev_done = '0;

    fork
      forever @(posedge PCLK) cyc++;
      // Slave responder: unselected slaves drive ready/error high with junk data.
      forever @(negedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.PSEL[i] && bus.PENABLE) begin
            if (wcnt[i] < waitcfg[i]) begin
              rdy[i] = 0; wcnt[i]++;
            end else begin
              rdy[i]  = 1;
              serr[i] = serrcfg[i];
              prd[i]  = smem.exists(bus.PADDR) ? smem[bus.PADDR] : 32'h0;
              if (bus.PWRITE && !serrcfg[i]) smem[bus.PADDR] = bus.PWDATA;
            end
          end else begin
            wcnt[i] = 0;
            rdy[i]  = !bus.PSEL[i];
            serr[i] = 1;
            prd[i]  = 32'hBAD0_0000 | 32'(i);
          end
        end
      end
      forever @(negedge PCLK) begin
        if (!PRESETn) begin
          prev_ok = 0;
        end else begin
          check("psel_onehot", 32'($onehot0(bus.PSEL)), 32'h1);
          if (bus.PENABLE) check("penable_has_psel", 32'(bus.PSEL != 0), 32'h1);
          if (prev_ok && prev_sel != 0 && !prev_en) begin
            check("setup_to_access", 32'(bus.PENABLE), 32'h1);
            check("setup_psel", 32'(bus.PSEL), 32'(prev_sel));
          end
          if (prev_ok && prev_en && bus.PENABLE) begin
            check("wait_psel", 32'(bus.PSEL), 32'(prev_sel));
            check("wait_paddr", bus.PADDR, prev_addr);
            check("wait_pwrite", 32'(bus.PWRITE), 32'(prev_wr));
            check("wait_pwdata", bus.PWDATA, prev_wdata);
          end
          if (bus.PSEL != 0) begin psel_cyc++; mon_psel = bus.PSEL; mon_paddr = bus.PADDR; end
          if (bus.PENABLE) pen_cyc++;
          check("done_onehot", 32'($onehot0(bus.REQ_DONE)), 32'h1);
          if (bus.REQ_DONE != 0) begin
            check("done_single_cycle", 32'(prev_done), 32'h0);
            p = bus.REQ_DONE[1] ? 1 : 0;
            last_rdata = bus.REQ_RDATA;
            last_err   = bus.REQ_ERR;
            if (exp_order.size() > 0) check("grant_order", 32'(p), 32'(exp_order.pop_front()));
            else check("unexpected_done", 32'(bus.REQ_DONE), 32'h0);
            if (p == 0 && exp_r0.size() > 0) r = exp_r0.pop_front();
            else if (p == 1 && exp_r1.size() > 0) r = exp_r1.pop_front();
            else r = '{32'hxxxx_xxxx, 1'bx};
            check("rdata", bus.REQ_RDATA, r.rdata);
            check("err", 32'(bus.REQ_ERR), 32'(r.err));
          end
          prev_ok = 1; prev_sel = bus.PSEL; prev_addr = bus.PADDR; prev_en = bus.PENABLE;
          prev_wr = bus.PWRITE; prev_wdata = bus.PWDATA; prev_done = bus.REQ_DONE;
        end
      end
    join_none

    #1 PRESETn = 0;
    repeat (3) @(negedge PCLK);
    check("rst_psel", 32'(bus.PSEL), 32'h0);
    check("rst_paddr", bus.PADDR, 32'h0);
    check("rst_penable", 32'(bus.PENABLE), 32'h0);
    check("rst_pwrite", 32'(bus.PWRITE), 32'h0);
    check("rst_pwdata", bus.PWDATA, 32'h0);
    check("rst_done", 32'(bus.REQ_DONE), 32'h0);
    check("rst_rdata", bus.REQ_RDATA, 32'h0);
    check("rst_err", 32'(bus.REQ_ERR), 32'h0);
    PRESETn = 1;

    // Contested arbitration straight out of reset: 0,1,0,1,...
    add(0, 1, 32'h0000_0010, 32'h1111_0000, -1); add(0, 0, 32'h0000_0010, 0, -1);
    add(0, 1, 32'h0000_0014, 32'h2222_0001, -1); add(0, 0, 32'h0000_0014, 0, -1);
    add(1, 1, 32'h0002_0020, 32'hA5A5_0000, -1); add(1, 0, 32'h0002_0020, 0, -1);
    add(1, 1, 32'h0002_0024, 32'h5A5A_0002, -1); add(1, 0, 32'h0002_0024, 0, -1);
    for (int k = 0; k < 8; k++) exp_order.push_back(k % 2);
    run(200);
    check("arb_drained", 32'(exp_r0.size() + exp_r1.size() + exp_order.size()), 32'h0);
    check("arb_last_rdata", last_rdata, 32'h5A5A_0002);

    // Single write then read on slave 1.
    add(0, 1, 32'h1000_0004, 32'hDEAD_BEEF, 3); add(0, 0, 32'h1000_0004, 0, 3);
    exp_order.push_back(0); exp_order.push_back(0);
    run(50);
    check("t1_psel", 32'(mon_psel), 32'h2);
    check("t1_paddr", mon_paddr, 32'h1000_0004);
    check("t1_rdata", last_rdata, 32'hDEAD_BEEF);
    check("t1_err", 32'(last_err), 32'h0);

    // Slave 3 read with five wait states.
    add(0, 1, 32'h0003_0010, 32'h3C3C_1234, 3); exp_order.push_back(0);
    run(50);
    waitcfg[3] = 5;
    n = pen_cyc;
    add(0, 0, 32'h0003_0010, 0, 8); exp_order.push_back(0);
    run(50);
    check("t3_penable_cycles", 32'(pen_cyc - n), 32'd6);
    check("t3_rdata", last_rdata, 32'h3C3C_1234);
    waitcfg[3] = 0;

    // Unmapped address.
    n = psel_cyc;
    add(0, 0, 32'h0004_0000, 0, 1); exp_order.push_back(0);
    run(50);
    check("miss_psel_cycles", 32'(psel_cyc - n), 32'h0);
    check("miss_err", 32'(last_err), 32'h1);
    check("miss_rdata", last_rdata, 32'h0);

    // Slave error on a slave-0 write.
    serrcfg[0] = 1;
    add(0, 1, 32'h0000_0040, 32'h0BAD_F00D, 3); exp_order.push_back(0);
    run(50);
    check("slverr_err", 32'(last_err), 32'h1);
    serrcfg[0] = 0;

    // Reset during ACCESS discards the transfer and re-favours requester 0.
    waitcfg[3] = 10;
    @(posedge PCLK); #1;
    v0 = 1; w0 = 0; a0 = 32'h0003_0010;
    n = 0;
    do begin @(negedge PCLK); n++; end while (!bus.PENABLE && n < 20);
    check("rst_reach_access", 32'(bus.PENABLE), 32'h1);
    @(posedge PCLK); #2;
    PRESETn = 0;
    #1;
    check("arst_psel", 32'(bus.PSEL), 32'h0);
    check("arst_penable", 32'(bus.PENABLE), 32'h0);
    check("arst_done", 32'(bus.REQ_DONE), 32'h0);
    v0 = 0;
    waitcfg[3] = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1;
    add(0, 0, 32'h0000_0010, 0, 3); add(1, 0, 32'h0002_0020, 0, -1);
    exp_order.push_back(0); exp_order.push_back(1);
    run(50);
    check("post_rst_rdata", last_rdata, 32'hA5A5_0000);
    repeat (3) @(negedge PCLK);
    check("final_drained", 32'(exp_r0.size() + exp_r1.size() + exp_order.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
